writeback_pc_update: RTL and testbench

WRITEBACK_PC_UPDATE -- requirements
Module: writeback_pc_update

---
 rtl/writeback_pc_update.sv | 162 ++++++++++++++++
 tb/tb_writeback_pc_update.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_pc_update.sv
// rtl/writeback_pc_update.sv - Y86-64 writeback stage: register file, PC update, status and retire counter
// A retiring instruction either commits (registers, pc, retired) or faults/halts and parks the block in STOP.
module writeback_pc_update #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] pc,
  output logic [1:0]  stat,
  output logic [31:0] retired
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_STOP = 1'b1;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [63:0] regs [0:14];
  logic [0:0]  state;
  logic [1:0]  stat_q;
  logic [63:0] pc_q;
  logic [31:0] retired_cnt;

  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] new_pc;
  logic        fault;
  logic [1:0]  fault_code;
  logic        accept;
  logic        commit;
  logic        stop;

  always_comb begin
    dst_e = REG_NONE;
    case (icode)
      I_RRMOVQ:                         dst_e = cnd ? rB : REG_NONE;
      I_IRMOVQ, I_OPQ:                  dst_e = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:   dst_e = REG_RSP;
      default:                          dst_e = REG_NONE;
    endcase
  end

  always_comb begin
    dst_m = REG_NONE;
    if (icode == I_MRMOVQ || icode == I_POPQ) begin
      dst_m = rA;
    end
  end

  always_comb begin
    new_pc = valP;
    if ((icode == I_JXX && cnd) || icode == I_CALL) begin
      new_pc = valC;
    end else if (icode == I_RET) begin
      new_pc = valM;
    end
  end

  // Fetch faults outrank decode faults, which outrank data faults; halt only if all clean.
  always_comb begin
    fault      = 1'b0;
    fault_code = STAT_AOK;
    if (imem_error) begin
      fault      = 1'b1;
      fault_code = STAT_ADR;
    end else if (!instr_valid) begin
      fault      = 1'b1;
      fault_code = STAT_INS;
    end else if (dmem_error) begin
      fault      = 1'b1;
      fault_code = STAT_ADR;
    end else if (icode == I_HALT) begin
      fault      = 1'b1;
      fault_code = STAT_HLT;
    end
  end

  assign accept = (state == S_RUN) && wb_en;
  assign commit = accept && !fault;
  assign stop   = accept && fault;

  // The dstM write is issued last so it wins when dstE and dstM collide (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end
    end else if (commit) begin
      if (dst_e != REG_NONE) begin
        regs[dst_e] <= valE;
      end
      if (dst_m != REG_NONE) begin
        regs[dst_m] <= valM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      stat_q      <= STAT_AOK;
      pc_q        <= RESET_PC;
      retired_cnt <= 32'h0;
    end else if (commit) begin
      pc_q        <= new_pc;
      retired_cnt <= retired_cnt + 32'd1;
    end else if (stop) begin
      state  <= S_STOP;
      stat_q <= fault_code;
    end
  end

  always_comb begin
    valA = 64'h0;
    valB = 64'h0;
    if (srcA != REG_NONE) begin
      valA = regs[srcA];
    end
    if (srcB != REG_NONE) begin
      valB = regs[srcB];
    end
  end

  assign pc      = pc_q;
  assign stat    = stat_q;
  assign retired = retired_cnt;

endmodule

// File: tb/tb_writeback_pc_update.sv
// tb/tb_writeback_pc_update.sv - directed and randomized bench for writeback_pc_update against a reference model
module tb_writeback_pc_update;

  localparam logic [63:0] RPC = 64'h100;
  localparam logic [63:0] RSP = 64'h1F0;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [63:0] valP;
  logic [63:0] valC;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] pc;
  logic [1:0]  stat;
  logic [31:0] retired;

  writeback_pc_update #(.RESET_PC(RPC), .RSP_INIT(RSP)) dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .icode(icode), .cnd(cnd),
    .rA(rA), .rB(rB), .valE(valE), .valM(valM), .valP(valP), .valC(valC),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .pc(pc), .stat(stat), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] m_regs [15];
  logic [63:0] m_pc;
  logic [1:0]  m_stat;
  logic [31:0] m_ret;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
    m_regs[4] = RSP;
    m_pc   = RPC;
    m_stat = 2'd0;
    m_ret  = 32'h0;
  endtask

  function automatic logic [63:0] model_read(input logic [3:0] id);
    return (id == 4'hF) ? 64'h0 : m_regs[id];
  endfunction

  // One retiring instruction as seen by the architecture: faults freeze, commits update.
  task automatic model_step();
    int de;
    int dm;
    if (m_stat != 2'd0 || !wb_en) return;
    if (imem_error)       m_stat = 2'd2;
    else if (!instr_valid) m_stat = 2'd3;
    else if (dmem_error)  m_stat = 2'd2;
    else if (icode == 0)  m_stat = 2'd1;
    else begin
      de = 15;
      dm = 15;
      if (icode == 2 && cnd) de = rB;
      if (icode == 3 || icode == 6) de = rB;
      if (icode >= 8 && icode <= 11) de = 4;
      if (icode == 5 || icode == 11) dm = rA;
      if (de != 15) m_regs[de] = valE;
      if (dm != 15) m_regs[dm] = valM;
      if ((icode == 7 && cnd) || icode == 8) m_pc = valC;
      else if (icode == 9) m_pc = valM;
      else m_pc = valP;
      m_ret = m_ret + 1;
    end
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic cycle();
    #1;
    check("valA_read", valA, model_read(srcA));
    check("valB_read", valB, model_read(srcB));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pc", pc, m_pc);
    check("stat", {62'h0, stat}, {62'h0, m_stat});
    check("retired", {32'h0, retired}, {32'h0, m_ret});
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [63:0] e, input logic [63:0] m, input logic [63:0] p, input logic [63:0] k);
    wb_en = 1'b1; icode = ic; rA = a; rB = b; cnd = c;
    valE = e; valM = m; valP = p; valC = k;
    instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
  endtask

  // Asserts reset mid-cycle with a commit pending, checks the asynchronous effect, releases at a negedge.
  task automatic do_reset();
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'hDEAD, 64'h0, 64'h999, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pc", pc, RPC);
    check("rst_async_stat", {62'h0, stat}, 64'h0);
    check("rst_async_retired", {32'h0, retired}, 64'h0);
    model_reset();
    @(negedge clk);
    check("rst_wins_retired", {32'h0, retired}, 64'h0);
    check("rst_wins_pc", pc, RPC);
    rst_n = 1'b1;
    wb_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    wb_en = 1'b0;
    srcA = 4'h4; srcB = 4'hF;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_pc", pc, RPC);
    check("reset_rsp", valA, RSP);
    check("reset_none", valB, 64'h0);
    rst_n = 1'b1;

    // irmovq $0x10, %rdx
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h10, 64'h0, 64'hA, 64'h0);
    srcA = 4'h2; srcB = 4'h4;
    cycle();
    check("irmov_reg2", valA, 64'h10);
    check("irmov_pc", pc, 64'hA);
    check("irmov_retired", {32'h0, retired}, 64'h1);

    // popq %rsp: valM wins over valE
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 64'hC, 64'h0);
    srcA = 4'h4;
    cycle();
    check("popq_rsp", valA, 64'h55);

    drive(4'h7, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h9, 64'h40);
    cycle();
    check("jxx_not_taken", pc, 64'h9);
    cnd = 1'b1;
    cycle();
    check("jxx_taken", pc, 64'h40);

    // counter wrap
    wb_en = 1'b0;
    force dut.retired_cnt = 32'hFFFFFFFF;
    #1 release dut.retired_cnt;
    m_ret = 32'hFFFFFFFF;
    @(negedge clk);
    check("preload_retired", {32'h0, retired}, 64'hFFFFFFFF);
    drive(4'h6, 4'h1, 4'h3, 1'b0, 64'h77, 64'h0, 64'h50, 64'h0);
    srcA = 4'h3;
    cycle();
    check("wrap_retired", {32'h0, retired}, 64'h0);

    // invalid instruction outranks data fault
    drive(4'h6, 4'h1, 4'h3, 1'b0, 64'h1234, 64'h0, 64'h60, 64'h0);
    instr_valid = 1'b0; dmem_error = 1'b1;
    cycle();
    check("ins_stat", {62'h0, stat}, 64'h3);
    check("ins_pc", pc, 64'h50);
    check("ins_reg3", valA, 64'h77);
    do_reset();

    // instruction-memory fault outranks invalid instruction
    drive(4'h6, 4'h1, 4'h3, 1'b0, 64'h1234, 64'h0, 64'h60, 64'h0);
    instr_valid = 1'b0; imem_error = 1'b1;
    cycle();
    check("adr_stat", {62'h0, stat}, 64'h2);
    check("adr_pc", pc, RPC);
    check("adr_reg3", valA, 64'h0);
    do_reset();

    // halt, then a commit attempt is ignored
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h1, 64'h0);
    cycle();
    check("hlt_stat", {62'h0, stat}, 64'h1);
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'hABC, 64'h0, 64'h20, 64'h0);
    srcA = 4'h2;
    cycle();
    check("stop_pc", pc, RPC);
    check("stop_reg2", valA, 64'h0);
    check("stop_stat", {62'h0, stat}, 64'h1);
    do_reset();

    for (int it = 0; it < 400; it++) begin
      if ((m_stat != 2'd0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        wb_en       = ($urandom_range(0, 3) != 0);
        icode       = ($urandom_range(0, 39) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
        cnd         = 1'($urandom_range(0, 1));
        rA          = 4'($urandom_range(0, 15));
        rB          = 4'($urandom_range(0, 15));
        valE        = {$urandom, $urandom};
        valM        = {$urandom, $urandom};
        valP        = {$urandom, $urandom};
        valC        = {$urandom, $urandom};
        instr_valid = ($urandom_range(0, 39) != 0);
        imem_error  = ($urandom_range(0, 49) == 0);
        dmem_error  = ($urandom_range(0, 29) == 0);
        srcA        = 4'($urandom_range(0, 15));
        srcB        = 4'($urandom_range(0, 15));
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
